sw_cmd_ctrl: RTL and testbench

//  Stopwatch command controller. Sits between the button edge detectors (1-clk pulses) and the stopwatch counter/FND path.

---
 rtl/sw_ctrl_pkg.sv | 35 +++
 rtl/sw_btn_arbiter.sv | 35 +++
 rtl/sw_cmd_ctrl.sv | 134 +++++++++++++
 tb/tb_sw_cmd_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_ctrl_pkg.sv
// Shared encodings for the stopwatch command controller.
// Build option: define SW_LAP_EN to add the lap button, the lap-hold output and UART code 'L'.
package sw_ctrl_pkg;

    localparam int CMD_W = 8;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [CMD_W-1:0] DEF_CODE_RUN  = 8'h52;
    localparam logic [CMD_W-1:0] DEF_CODE_CLR  = 8'h43;
    localparam logic [CMD_W-1:0] DEF_CODE_MODE = 8'h4D;
    localparam logic [CMD_W-1:0] CODE_LAP      = 8'h4C;

    // Event bit positions; a lower index means a higher grant priority.
    localparam int EV_RUN  = 0;
    localparam int EV_CLR  = 1;
    localparam int EV_MODE = 2;
`ifdef SW_LAP_EN
    localparam int EV_LAP  = 3;
    localparam int EV_W    = 4;
`else
    localparam int EV_W    = 3;
`endif

    typedef logic [EV_W-1:0] ev_t;

    function automatic ev_t first_set(input ev_t v);
        return v & (~v + ev_t'(1));
    endfunction

endpackage

// File: rtl/sw_btn_arbiter.sv
// Button pend latches with a fixed-priority, one-event-per-clock grant.
// Build option: SW_LAP_EN widens the event vector by one lap bit (via the package).
module sw_btn_arbiter
    import sw_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [EV_W-1:0] pulse,
    output logic [EV_W-1:0] grant,
    output logic            uart_ok
);

    logic [EV_W-1:0] pend;

    always_comb begin
        grant = '0;
        if (en) begin
            grant = first_set(pend);
        end
    end

    assign uart_ok = en & ~|pend & ~|pulse;

    // NOTE: the granted bit is cleared before new pulses are OR-ed in, so a pulse
    // landing on the same edge its bit is granted becomes a fresh pending event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~grant) | pulse;
        end
    end

endmodule

// File: rtl/sw_cmd_ctrl.sv
// Stopwatch command controller: merges button events and UART commands into the STOP/RUN/CLEAR FSM.
// Build option: define SW_LAP_EN to add i_btn_lap, o_lap_hold and UART code 'L'.
module sw_cmd_ctrl
    import sw_ctrl_pkg::*;
#(
    parameter int               CLR_CYCLES = 4,
    parameter logic [CMD_W-1:0] CODE_RUN   = DEF_CODE_RUN,
    parameter logic [CMD_W-1:0] CODE_CLR   = DEF_CODE_CLR,
    parameter logic [CMD_W-1:0] CODE_MODE  = DEF_CODE_MODE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_btn_run,
    input  logic             i_btn_clr,
    input  logic             i_btn_mode,
`ifdef SW_LAP_EN
    input  logic             i_btn_lap,
`endif
    input  logic             i_cmd_valid,
    input  logic [CMD_W-1:0] i_cmd_data,
    output logic             o_cmd_ready,
    output logic             o_run,
    output logic             o_clear,
    output logic             o_mode,
`ifdef SW_LAP_EN
    output logic             o_lap_hold,
`endif
    output logic [1:0]       o_state
);

    localparam int CNT_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    state_t          state;
    logic [CNT_W-1:0] clr_cnt;
    logic [EV_W-1:0] pulse;
    logic [EV_W-1:0] btn_ev;
    logic [EV_W-1:0] cmd_ev;
    logic [EV_W-1:0] ev;
    logic            uart_ok;

    always_comb begin
        pulse          = '0;
        pulse[EV_RUN]  = i_btn_run;
        pulse[EV_CLR]  = i_btn_clr;
        pulse[EV_MODE] = i_btn_mode;
`ifdef SW_LAP_EN
        pulse[EV_LAP]  = i_btn_lap;
`endif
    end

    sw_btn_arbiter u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state != ST_CLEAR),
        .pulse   (pulse),
        .grant   (btn_ev),
        .uart_ok (uart_ok)
    );

    // Unknown codes still complete the handshake but map to no event.
    always_comb begin
        cmd_ev = '0;
        if (i_cmd_valid && uart_ok) begin
            if (i_cmd_data == CODE_RUN)       cmd_ev[EV_RUN]  = 1'b1;
            else if (i_cmd_data == CODE_CLR)  cmd_ev[EV_CLR]  = 1'b1;
            else if (i_cmd_data == CODE_MODE) cmd_ev[EV_MODE] = 1'b1;
`ifdef SW_LAP_EN
            else if (i_cmd_data == CODE_LAP)  cmd_ev[EV_LAP]  = 1'b1;
`endif
        end
    end

    // uart_ok already excludes any pending button, so the two sources never overlap.
    assign ev          = btn_ev | cmd_ev;
    assign o_cmd_ready = uart_ok;
    assign o_state     = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_STOP;
            o_run      <= 1'b0;
            o_clear    <= 1'b0;
            o_mode     <= 1'b0;
            clr_cnt    <= '0;
`ifdef SW_LAP_EN
            o_lap_hold <= 1'b0;
`endif
        end else begin
            if (ev[EV_MODE]) begin
                o_mode <= ~o_mode;
            end
            case (state)
                ST_STOP: begin
                    if (ev[EV_RUN]) begin
                        state <= ST_RUN;
                        o_run <= 1'b1;
                    end else if (ev[EV_CLR]) begin
                        state      <= ST_CLEAR;
                        o_clear    <= 1'b1;
                        clr_cnt    <= CNT_W'(CLR_CYCLES - 1);
`ifdef SW_LAP_EN
                        o_lap_hold <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    if (ev[EV_RUN]) begin
                        state <= ST_STOP;
                        o_run <= 1'b0;
                    end
`ifdef SW_LAP_EN
                    if (ev[EV_LAP]) begin
                        o_lap_hold <= ~o_lap_hold;
                    end
`endif
                end
                ST_CLEAR: begin
                    if (clr_cnt == '0) begin
                        state   <= ST_STOP;
                        o_clear <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= ST_STOP;
                    o_run   <= 1'b0;
                    o_clear <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_cmd_ctrl.sv
// Self-checking bench for sw_cmd_ctrl: directed scenarios then random traffic against an event-level model.
// Build option: SW_LAP_EN enables the lap-button scenario and lap traffic.
module tb_sw_cmd_ctrl;
    import sw_ctrl_pkg::*;

    localparam int CLR_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_run = 1'b0, btn_clr = 1'b0, btn_mode = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, run, clear, mode;
    logic [1:0] state;
`ifdef SW_LAP_EN
    logic       btn_lap = 1'b0;
    logic       lap_hold;
`endif

    sw_cmd_ctrl #(.CLR_CYCLES(CLR_CYCLES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_btn_run   (btn_run),
        .i_btn_clr   (btn_clr),
        .i_btn_mode  (btn_mode),
`ifdef SW_LAP_EN
        .i_btn_lap   (btn_lap),
`endif
        .i_cmd_valid (cmd_valid),
        .i_cmd_data  (cmd_data),
        .o_cmd_ready (cmd_ready),
        .o_run       (run),
        .o_clear     (clear),
        .o_mode      (mode),
`ifdef SW_LAP_EN
        .o_lap_hold  (lap_hold),
`endif
        .o_state     (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pending events as flags, CLEAR tracked as clock cycles of o_clear still owed.
    bit m_pend [4];
    int m_left;
    bit m_run, m_mode, m_lap;
    bit m_last_acc;
    bit last_ready;
    int n_accepted = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit [3:0] pulses();
        bit [3:0] p;
        p = {1'b0, btn_mode, btn_clr, btn_run};
`ifdef SW_LAP_EN
        p[3] = btn_lap;
`endif
        return p;
    endfunction

    function automatic bit m_ready();
        return (m_left == 0) && !(m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3]) && (pulses() == 4'd0);
    endfunction

    function automatic int code_to_ev(input logic [7:0] code);
        case (code)
            8'h52:   return 0;
            8'h43:   return 1;
            8'h4D:   return 2;
`ifdef SW_LAP_EN
            8'h4C:   return 3;
`endif
            default: return -1;
        endcase
    endfunction

    task automatic m_step();
        bit       busy, rdy;
        int       ev;
        bit [3:0] p;
        m_last_acc = 1'b0;
        if (!rst_n) begin
            foreach (m_pend[k]) m_pend[k] = 1'b0;
            m_left = 0; m_run = 0; m_mode = 0; m_lap = 0;
            return;
        end
        busy = (m_left > 0);
        rdy  = m_ready();
        p    = pulses();
        ev   = -1;
        if (!busy) begin
            for (int k = 0; k < 4; k++) begin
                if (m_pend[k] && ev < 0) begin
                    ev = k;
                    m_pend[k] = 1'b0;
                end
            end
            if (ev < 0 && rdy && cmd_valid) begin
                ev = code_to_ev(cmd_data);
                m_last_acc = 1'b1;
                n_accepted++;
            end
        end
        for (int k = 0; k < 4; k++) if (p[k]) m_pend[k] = 1'b1;
        if (busy) m_left--;
        case (ev)
            0: m_run = !m_run;
            1: if (!m_run) begin m_left = CLR_CYCLES; m_lap = 1'b0; end
            2: m_mode = !m_mode;
            3: if (m_run) m_lap = !m_lap;
            default: ;
        endcase
    endtask

    // One clock: ready checked mid-cycle, registered outputs checked just after the edge.
    task automatic tick();
        @(negedge clk);
        last_ready = cmd_ready;
        check("ready", cmd_ready, m_ready());
        @(posedge clk);
        m_step();
        #1;
        check("run",   run,   m_run);
        check("clear", clear, m_left > 0);
        check("mode",  mode,  m_mode);
        check("state", state, (m_left > 0) ? 2 : (m_run ? 1 : 0));
`ifdef SW_LAP_EN
        check("lap_hold", lap_hold, m_lap);
        btn_lap = 1'b0;
`endif
        btn_run  = 1'b0;
        btn_clr  = 1'b0;
        btn_mode = 1'b0;
    endtask

    initial begin
        int cnt;
        int waits;
        int acc0;
        logic [7:0] codes [6];
        codes = '{8'h52, 8'h43, 8'h4D, 8'h4C, 8'h58, 8'h00};

        // Reset
        repeat (2) @(posedge clk);
        #1;
        m_step();
        repeat (3) tick();
        check("rst_state", state, 0);
        check("rst_ready", cmd_ready, 1);
        rst_n = 1'b1;

        // Run/stop toggle with two-clock button latency
        repeat (5) tick();
        btn_run = 1'b1;
        tick();
        check("t1_latency", run, 0);
        tick();
        check("t1_run", run, 1);
        check("t1_state", state, 1);
        btn_run = 1'b1;
        tick(); tick();
        check("t1_stop", run, 0);

        // Clear from STOP lasts exactly CLR_CYCLES; clear in RUN is ignored
        btn_clr = 1'b1;
        tick(); tick();
        check("t2_state_clear", state, 2);
        cnt = (clear === 1'b1) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (clear === 1'b1) cnt++;
            else break;
        end
        check("t2_clear_len", cnt, CLR_CYCLES);
        check("t2_state_stop", state, 0);
        btn_run = 1'b1;
        tick(); tick();
        btn_clr = 1'b1;
        tick(); tick();
        check("t2_run_noclear", clear, 0);
        check("t2_run_state", state, 1);
        btn_run = 1'b1;
        tick(); tick();

        // Simultaneous run/clr/mode from STOP
        btn_run = 1'b1; btn_clr = 1'b1; btn_mode = 1'b1;
        tick(); tick();
        check("t3_run_first", run, 1);
        tick();
        check("t3_clr_ignored", clear, 0);
        tick();
        check("t3_mode", mode, 1);
        check("t3_state", state, 1);
        btn_run = 1'b1;
        tick(); tick();

        // UART command held while a button pulse arrives
        cmd_valid = 1'b1; cmd_data = 8'h52; btn_mode = 1'b1;
        acc0 = n_accepted;
        tick();
        check("t4_ready_low", last_ready, 0);
        for (int i = 0; i < 10 && !m_last_acc; i++) tick();
        cmd_valid = 1'b0;
        check("t4_accepted_once", n_accepted - acc0, 1);
        check("t4_run", run, 1);
        check("t4_mode", mode, 0);
        btn_run = 1'b1;
        tick(); tick();

        // Unknown code, then a command stalled by CLEAR
        cmd_valid = 1'b1; cmd_data = 8'h58;
        tick();
        check("t5_unknown_ready", last_ready, 1);
        cmd_valid = 1'b0;
        btn_clr = 1'b1;
        tick(); tick();
        cmd_valid = 1'b1; cmd_data = 8'h4D;
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_ready) break;
            waits++;
        end
        cmd_valid = 1'b0;
        check("t5_stall_cycles", waits, CLR_CYCLES);
        check("t5_mode", mode, 1);
        check("t5_state", state, 0);

        // Reset during the second clock of CLEAR
        btn_clr = 1'b1;
        tick(); tick(); tick();
        check("t6_in_clear", clear, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_clear_off", clear, 0);
        check("t6_state", state, 0);

`ifdef SW_LAP_EN
        btn_run = 1'b1;
        tick(); tick();
        btn_lap = 1'b1;
        tick(); tick();
        check("lap_set", lap_hold, 1);
        btn_run = 1'b1;
        tick(); tick();
        check("lap_kept_stop", lap_hold, 1);
        btn_clr = 1'b1;
        tick(); tick();
        check("lap_cleared", lap_hold, 0);
        repeat (CLR_CYCLES + 1) tick();
`endif

        // Random traffic; a command stays on the bus until accepted
        for (int i = 0; i < 600; i++) begin
            btn_run  = ($urandom_range(0, 9) == 0);
            btn_clr  = ($urandom_range(0, 11) == 0);
            btn_mode = ($urandom_range(0, 9) == 0);
`ifdef SW_LAP_EN
            btn_lap  = ($urandom_range(0, 9) == 0);
`endif
            if (!cmd_valid || m_last_acc) begin
                cmd_valid = ($urandom_range(0, 2) == 0);
                cmd_data  = codes[$urandom_range(0, 5)];
            end
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
